// File: rtl/vx_mem_reorder_pkg.sv
// Shared helpers for the memory reorder buffer: perf counter width and saturating increment.
package vx_mem_reorder_pkg;

  localparam int PERF_CNT_W = 32;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/vx_mem_reorder_index_alloc.sv
// Circular slot allocator: head/tail/count bookkeeping, registered state, no backpressure of its own.
// full reflects the registered count, so a same-cycle release never frees a slot for a same-cycle alloc.
module vx_mem_reorder_index_alloc
  import vx_mem_reorder_pkg::*;
#(
  parameter int SIZE = 16,
  localparam int SLOT_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alloc_i,
  input  logic                  release_i,
  output logic [SLOT_WIDTH-1:0] head_o,
  output logic [SLOT_WIDTH-1:0] tail_o,
  output logic                  full_o
);

  logic [SLOT_WIDTH-1:0] head_q, head_d;
  logic [SLOT_WIDTH-1:0] tail_q, tail_d;
  logic [SLOT_WIDTH:0]   count_q, count_d;

  // SIZE is a power of two, so natural overflow of the pointers is the wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc_i)   tail_d = tail_q + SLOT_WIDTH'(1);
    if (release_i) head_d = head_q + SLOT_WIDTH'(1);
    case ({alloc_i, release_i})
      2'b10:   count_d = count_q + (SLOT_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (SLOT_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o = head_q;
  assign tail_o = tail_q;
  assign full_o = (count_q == (SLOT_WIDTH+1)'(SIZE));

endmodule

// File: rtl/vx_mem_reorder.sv
// Tags reads with slot ids downstream and returns responses in request order; 1-cycle min rsp latency.
// Reads stall on in_req_ready when all slots are in flight; optional perf_full_stalls via VX_MEM_REORDER_PERF_EN.
module vx_mem_reorder
  import vx_mem_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 16,
  parameter int SIZE       = 16,
  localparam int SLOT_WIDTH = $clog2(SIZE),
  localparam int BYTEENW    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_req_valid,
  input  logic                  in_req_rw,
  input  logic [BYTEENW-1:0]    in_req_byteen,
  input  logic [ADDR_WIDTH-1:0] in_req_addr,
  input  logic [DATA_WIDTH-1:0] in_req_data,
  input  logic [TAG_WIDTH-1:0]  in_req_tag,
  output logic                  in_req_ready,
  output logic                  out_req_valid,
  output logic                  out_req_rw,
  output logic [BYTEENW-1:0]    out_req_byteen,
  output logic [ADDR_WIDTH-1:0] out_req_addr,
  output logic [DATA_WIDTH-1:0] out_req_data,
  output logic [SLOT_WIDTH-1:0] out_req_tag,
  input  logic                  out_req_ready,
  input  logic                  in_rsp_valid,
  input  logic [DATA_WIDTH-1:0] in_rsp_data,
  input  logic [SLOT_WIDTH-1:0] in_rsp_tag,
  output logic                  in_rsp_ready,
  output logic                  out_rsp_valid,
  output logic [DATA_WIDTH-1:0] out_rsp_data,
  output logic [TAG_WIDTH-1:0]  out_rsp_tag,
  input  logic                  out_rsp_ready
`ifdef VX_MEM_REORDER_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_full_stalls
`endif
);

  logic [SLOT_WIDTH-1:0] head, tail;
  logic                  full;
  logic                  alloc, pop;
  logic [SIZE-1:0]       done_q, done_d;
  logic                  rsp_mask_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [SIZE];
  logic [DATA_WIDTH-1:0] data_mem [SIZE];

  assign out_req_rw     = in_req_rw;
  assign out_req_byteen = in_req_byteen;
  assign out_req_addr   = in_req_addr;
  assign out_req_data   = in_req_data;
  assign out_req_tag    = in_req_rw ? '0 : tail;

  // Reads are held off downstream while in reset; writes never need a slot.
  assign out_req_valid = in_req_valid && (in_req_rw || (!full && reset_n));
  assign in_req_ready  = out_req_ready && (in_req_rw || !full);
  assign alloc         = in_req_valid && in_req_ready && !in_req_rw;

  assign in_rsp_ready  = 1'b1;
  assign out_rsp_valid = done_q[head] && reset_n;
  assign out_rsp_data  = data_mem[head];
  assign out_rsp_tag   = tag_mem[head];
  assign pop           = out_rsp_valid && out_rsp_ready;

  vx_mem_reorder_index_alloc #(
    .SIZE (SIZE)
  ) u_index_alloc (
    .clk       (clk),
    .reset_n   (reset_n),
    .alloc_i   (alloc),
    .release_i (pop),
    .head_o    (head),
    .tail_o    (tail),
    .full_o    (full)
  );

  always_ff @(posedge clk) begin
    if (alloc)        tag_mem[tail]        <= in_req_tag;
    if (in_rsp_valid) data_mem[in_rsp_tag] <= in_rsp_data;
  end

  // A response landing right after reset belongs to a discarded request.
  always_comb begin
    done_d = done_q;
    if (in_rsp_valid && !rsp_mask_q) done_d[in_rsp_tag] = 1'b1;
    if (pop)                         done_d[head]       = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_q     <= '0;
      rsp_mask_q <= 1'b1;
    end else begin
      done_q     <= done_d;
      rsp_mask_q <= 1'b0;
    end
  end

`ifdef VX_MEM_REORDER_PERF_EN
  logic [PERF_CNT_W-1:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
    end else if (in_req_valid && !in_req_rw && full) begin
      perf_stall_q <= sat_inc(perf_stall_q);
    end
  end

  assign perf_full_stalls = perf_stall_q;
`endif

endmodule

// File: tb/tb_vx_mem_reorder.sv
// Directed + randomized bench for vx_mem_reorder against an in-order queue reference model.
module tb_vx_mem_reorder;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int TW   = 8;
  localparam int SIZE = 4;
  localparam int SW   = 2;
  localparam int BW   = DW / 8;
  localparam int STREAM_LIMIT = 600;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_req_valid, in_req_rw, in_req_ready;
  logic [BW-1:0] in_req_byteen;
  logic [AW-1:0] in_req_addr;
  logic [DW-1:0] in_req_data;
  logic [TW-1:0] in_req_tag;
  logic          out_req_valid, out_req_rw, out_req_ready;
  logic [BW-1:0] out_req_byteen;
  logic [AW-1:0] out_req_addr;
  logic [DW-1:0] out_req_data;
  logic [SW-1:0] out_req_tag;
  logic          in_rsp_valid, in_rsp_ready;
  logic [DW-1:0] in_rsp_data;
  logic [SW-1:0] in_rsp_tag;
  logic          out_rsp_valid, out_rsp_ready;
  logic [DW-1:0] out_rsp_data;
  logic [TW-1:0] out_rsp_tag;
`ifdef VX_MEM_REORDER_PERF_EN
  logic [31:0]   perf_full_stalls;
`endif

  vx_mem_reorder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TAG_WIDTH  (TW),
    .SIZE       (SIZE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_req_valid   (in_req_valid),
    .in_req_rw      (in_req_rw),
    .in_req_byteen  (in_req_byteen),
    .in_req_addr    (in_req_addr),
    .in_req_data    (in_req_data),
    .in_req_tag     (in_req_tag),
    .in_req_ready   (in_req_ready),
    .out_req_valid  (out_req_valid),
    .out_req_rw     (out_req_rw),
    .out_req_byteen (out_req_byteen),
    .out_req_addr   (out_req_addr),
    .out_req_data   (out_req_data),
    .out_req_tag    (out_req_tag),
    .out_req_ready  (out_req_ready),
    .in_rsp_valid   (in_rsp_valid),
    .in_rsp_data    (in_rsp_data),
    .in_rsp_tag     (in_rsp_tag),
    .in_rsp_ready   (in_rsp_ready),
    .out_rsp_valid  (out_rsp_valid),
    .out_rsp_data   (out_rsp_data),
    .out_rsp_tag    (out_rsp_tag),
    .out_rsp_ready  (out_rsp_ready)
`ifdef VX_MEM_REORDER_PERF_EN
    ,
    .perf_full_stalls (perf_full_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding reads in request order, plus which slots have data back.
  logic [TW-1:0] m_tag_q[$];
  int            m_slot_q[$];
  bit            m_seen[SIZE];
  logic [DW-1:0] m_dat[SIZE];
  int            alloc_cnt;
  bit            m_just_rst;
  logic [TW-1:0] dut_pops[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tag_q.delete();
    m_slot_q.delete();
    foreach (m_seen[k]) m_seen[k] = 1'b0;
    alloc_cnt  = 0;
    m_just_rst = 1'b1;
  endtask

  // One clock: check outputs mid-low-phase against the model, then apply the edge to the model.
  task automatic step();
    bit            full_m, exp_v, rd, pp, rv;
    int            rslot;
    logic [DW-1:0] rdat;
    logic [TW-1:0] rtag;
    @(negedge clk);
    full_m = (m_slot_q.size() == SIZE);
    exp_v  = reset_n && (m_slot_q.size() > 0) && m_seen[m_slot_q[0]];
    chk("in_req_ready", in_req_ready, out_req_ready && (in_req_rw || !full_m));
    chk("out_req_valid", out_req_valid, in_req_valid && (in_req_rw || (!full_m && reset_n)));
    if (in_req_valid) chk("out_req_tag", out_req_tag, in_req_rw ? 0 : alloc_cnt % SIZE);
    chk("out_req_pass", {out_req_rw, out_req_byteen, out_req_addr, out_req_data},
        {in_req_rw, in_req_byteen, in_req_addr, in_req_data});
    chk("in_rsp_ready", in_rsp_ready, 1);
    chk("out_rsp_valid", out_rsp_valid, exp_v);
    if (exp_v) begin
      chk("out_rsp_tag", out_rsp_tag, m_tag_q[0]);
      chk("out_rsp_data", out_rsp_data, m_dat[m_slot_q[0]]);
    end
    if (out_rsp_valid && out_rsp_ready) dut_pops.push_back(out_rsp_tag);
    rd    = reset_n && in_req_valid && !in_req_rw && out_req_ready && !full_m;
    pp    = exp_v && out_rsp_ready;
    rv    = in_rsp_valid;
    rslot = int'(in_rsp_tag);
    rdat  = in_rsp_data;
    rtag  = in_req_tag;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (pp) begin
        m_seen[m_slot_q[0]] = 1'b0;
        void'(m_slot_q.pop_front());
        void'(m_tag_q.pop_front());
      end
      if (rv && !m_just_rst) begin
        m_seen[rslot] = 1'b1;
        m_dat[rslot]  = rdat;
      end
      if (rd) begin
        m_tag_q.push_back(rtag);
        m_slot_q.push_back(alloc_cnt % SIZE);
        alloc_cnt++;
      end
      m_just_rst = 1'b0;
    end
  endtask

  task automatic respond(input int slot, input logic [DW-1:0] d);
    in_rsp_valid = 1'b1;
    in_rsp_tag   = SW'(slot);
    in_rsp_data  = d;
  endtask

  initial begin
    int pend[$];
    int cyc;
    int target;
    int pops_before;

    reset_n = 1'b0;
    in_req_valid = 1'b0; in_req_rw = 1'b0; in_req_byteen = '0; in_req_addr = '0;
    in_req_data = '0; in_req_tag = '0; out_req_ready = 1'b1;
    in_rsp_valid = 1'b0; in_rsp_data = '0; in_rsp_tag = '0; out_rsp_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    in_req_valid = 1'b1; in_req_rw = 1'b1; in_req_addr = 8'h3C; in_req_byteen = 4'hA;
    step();
    chk("rst_out_rsp_valid", out_rsp_valid, 0);
    in_req_valid = 1'b0; in_req_rw = 1'b0;
    reset_n = 1'b1;

    // Single read: tag 0x5A on slot 0, data returns one cycle after the response.
    in_req_valid = 1'b1; in_req_tag = 8'h5A; in_req_addr = 8'h11; in_req_data = 32'h1234;
    #1 chk("t1_alloc_slot", out_req_tag, 0);
    step();
    in_req_valid = 1'b0;
    respond(0, 32'hDEAD);
    step();
    in_rsp_valid = 1'b0;
    #1;
    chk("t1_rsp_valid", out_rsp_valid, 1);
    chk("t1_rsp_tag", out_rsp_tag, 8'h5A);
    chk("t1_rsp_data", out_rsp_data, 32'hDEAD);
    step();
    chk("t1_drained", out_rsp_valid, 0);

    // Reorder: tags 1,2,3 land on slots 1,2,3; responses arrive 3,1,2.
    in_req_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_req_tag = TW'(i);
      step();
    end
    in_req_valid = 1'b0;
    dut_pops.delete();
    respond(3, 32'h300);
    step();
    #1 chk("t2_no_early", out_rsp_valid, 0);
    respond(1, 32'h100);
    step();
    respond(2, 32'h200);
    step();
    in_rsp_valid = 1'b0;
    step();
    step();
    step();
    chk("t2_pop_count", dut_pops.size(), 3);
    if (dut_pops.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t2_pop_order", dut_pops[i], i + 1);
    end

    // Full: four reads fill every slot, a fifth is held off.
    in_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_req_tag = TW'(8'h10 + i);
      step();
    end
    in_req_tag = 8'h14;
    #1 chk("t3_full_blocks_read", in_req_ready, 0);
    for (int i = 0; i < 7; i++) step();
`ifdef VX_MEM_REORDER_PERF_EN
    chk("t3_perf_full_stalls", perf_full_stalls, 7);
`endif
    in_req_rw = 1'b1;
    #1;
    chk("t3_write_ready", in_req_ready, 1);
    chk("t3_write_valid", out_req_valid, 1);
    chk("t3_write_tag", out_req_tag, 0);
    step();
    in_req_rw = 1'b0;
    respond(0, 32'hA0A0);
    step();
    in_rsp_valid = 1'b0;
    #1;
    chk("t3_pop_pending", out_rsp_valid, 1);
    chk("t3_same_cycle_no_free", in_req_ready, 0);
    step();
    #1;
    chk("t3_freed_ready", in_req_ready, 1);
    chk("t3_wrap_slot", out_req_tag, 0);
    step();
    in_req_valid = 1'b0;

    // Back-pressure: head done with ready low must hold its outputs.
    out_rsp_ready = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      respond(s % SIZE, 32'hB000 + DW'(s));
      step();
    end
    in_rsp_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold_tag", out_rsp_tag, 8'h11);
      chk("t4_hold_data", out_rsp_data, 32'hB001);
    end
    out_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t4_drained", out_rsp_valid, 0);

    // Random stream across several wraps with out-of-order responses.
    target = alloc_cnt + 3 * SIZE;
    pops_before = dut_pops.size();
    cyc = 0;
    while ((alloc_cnt < target || m_slot_q.size() > 0) && cyc < STREAM_LIMIT) begin
      in_req_rw     = ($urandom_range(0, 4) == 0);
      in_req_valid  = in_req_rw ? 1'b1 : ((alloc_cnt < target) && ($urandom_range(0, 3) != 0));
      in_req_tag    = TW'($urandom);
      in_req_addr   = AW'($urandom);
      in_req_data   = $urandom;
      in_req_byteen = BW'($urandom);
      out_req_ready = ($urandom_range(0, 4) != 0);
      out_rsp_ready = ($urandom_range(0, 3) != 0);
      in_rsp_valid  = 1'b0;
      pend.delete();
      foreach (m_slot_q[k]) if (!m_seen[m_slot_q[k]]) pend.push_back(m_slot_q[k]);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1)
        respond(pend[$urandom_range(0, pend.size() - 1)], $urandom);
      step();
      cyc++;
    end
    in_req_valid = 1'b0; in_req_rw = 1'b0; in_rsp_valid = 1'b0;
    out_req_ready = 1'b1; out_rsp_ready = 1'b1;
    chk("t5_stream_timeout", cyc < STREAM_LIMIT, 1);
    chk("t5_stream_pops", dut_pops.size() - pops_before, 3 * SIZE);

    // Reset with reads in flight; a stale response right after reset is dropped.
    in_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_req_tag = TW'(8'h21 + i);
      step();
    end
    in_req_valid = 1'b0;
    respond(m_slot_q[1], 32'h5555);
    step();
    in_rsp_valid = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1 chk("t6_rsp_valid_after_rst", out_rsp_valid, 0);
    in_req_valid = 1'b1; in_req_tag = 8'h30;
    respond(0, 32'hBAD);
    #1 chk("t6_new_slot0", out_req_tag, 0);
    step();
    in_req_valid = 1'b0; in_rsp_valid = 1'b0;
    step();
    chk("t6_stale_ignored", out_rsp_valid, 0);
    respond(0, 32'h3333);
    step();
    in_rsp_valid = 1'b0;
    #1;
    chk("t6_rsp_valid", out_rsp_valid, 1);
    chk("t6_rsp_tag", out_rsp_tag, 8'h30);
    chk("t6_rsp_data", out_rsp_data, 32'h3333);
    step();
    step();
    chk("t6_empty", out_rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_mem_reorder.md
VX_MEM_REORDER -- requirements
Module: VX_mem_reorder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning memory data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, meaning memory line address width.
REQ-003 SHALL have parameter TAG_WIDTH, default 16, meaning the upstream request tag width.
REQ-004 SHALL have parameter SIZE, default 16, meaning the number of reorder slots; it must be a power of two and at least 2.
REQ-005 SHALL have derived parameters SLOT_WIDTH = log2(SIZE) and BYTEENW = DATA_WIDTH/8.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have upstream request inputs in_req_valid (1), in_req_rw (1), in_req_byteen (BYTEENW), in_req_addr (ADDR_WIDTH), in_req_data (DATA_WIDTH) and in_req_tag (TAG_WIDTH), plus output in_req_ready (1).
REQ-009 SHALL have downstream request outputs out_req_valid, out_req_rw, out_req_byteen, out_req_addr, out_req_data and out_req_tag (SLOT_WIDTH), plus input out_req_ready.
REQ-010 SHALL have downstream response inputs in_rsp_valid (1), in_rsp_data (DATA_WIDTH) and in_rsp_tag (SLOT_WIDTH), plus output in_rsp_ready (1).
REQ-011 SHALL have upstream in-order response outputs out_rsp_valid (1), out_rsp_data (DATA_WIDTH) and out_rsp_tag (TAG_WIDTH), plus input out_rsp_ready (1).

Function
REQ-012 SHALL pass the request path through combinationally; out_req_rw, byteen, addr and data SHALL equal the corresponding in_req_* signals.
REQ-013 SHALL drive out_req_valid = in_req_valid && (in_req_rw || !full).
REQ-014 SHALL drive in_req_ready = out_req_ready && (in_req_rw || !full).
REQ-015 SHALL, on a read handshake (in_req_valid && in_req_ready && !in_req_rw), store in_req_tag in tag_mem[tail], drive out_req_tag = tail, increment tail modulo SIZE, and increment count.
REQ-016 SHALL pass writes without allocating a slot; out_req_tag SHALL be 0 for writes.
REQ-017 SHALL assert full exactly when count == SIZE; count SHALL be SLOT_WIDTH+1 bits wide.
REQ-018 SHALL use the previous-cycle value of full when deciding allocation; a pop in the same cycle SHALL NOT free a slot for a same-cycle allocation.
REQ-019 SHALL tie in_rsp_ready to 1, because every legal response has a reserved slot.
REQ-020 SHALL, on in_rsp_valid, write in_rsp_data to data_mem[in_rsp_tag] and set done[in_rsp_tag] at the next edge.
REQ-021 SHALL drive out_rsp_valid = done[head], out_rsp_data = data_mem[head] and out_rsp_tag = tag_mem[head].
REQ-022 SHALL give a minimum latency of 1 cycle from in_rsp_valid for the head slot to out_rsp_valid.
REQ-023 SHALL hold out_rsp_valid, out_rsp_data and out_rsp_tag stable while out_rsp_valid && !out_rsp_ready.
REQ-024 SHALL, on a pop (out_rsp_valid && out_rsp_ready), clear done[head], increment head modulo SIZE, and decrement count.
REQ-025 SHALL, on simultaneous allocate and pop, leave count unchanged while both head and tail advance.
REQ-026 SHALL allow a response write and a pop to different slots in the same cycle.
REQ-027 SHALL keep head and tail wrapping correctly from SIZE-1 to 0.

Reset
REQ-028 SHALL, when reset_n is low at a clk edge, clear head, tail, count and all done bits; data_mem and tag_mem are not reset.
REQ-029 SHALL hold out_rsp_valid=0, out_req_valid=in_req_valid&&in_req_rw and in_req_ready=out_req_ready during and after reset; in-flight responses are discarded.
REQ-030 SHALL ignore a response arriving on the first cycle after reset (its slot is not done-set into a stale state).

Configuration
REQ-031 SHALL, when macro VX_MEM_REORDER_PERF_EN is defined, add output perf_full_stalls (32 bits); it counts cycles with in_req_valid && !in_req_rw && full, saturates at 2^32-1, and resets to 0.
REQ-032 SHALL, without VX_MEM_REORDER_PERF_EN, omit the port and counter logic entirely; behaviour SHALL be otherwise identical.

Structure
REQ-033 SHALL place no block-specific types in a shared package; the slot index width SHALL be derived locally, and the debug macros SHALL come from the common defines header.
REQ-034 SHALL implement head/tail/count bookkeeping as one sub-module, VX_reorder_index_alloc, with inputs alloc and release and outputs head, tail and full; data_mem, tag_mem and done SHALL live in the top module.

Verification
REQ-035 Single read: req tag=0x5A, response data=0xDEAD on slot 0 -> out_rsp_valid one cycle later with tag=0x5A and data=0xDEAD; count returns to 0.
REQ-036 Reorder: reads with tags 1,2,3 get responses in slot order 2,0,1 -> out_rsp tags are emitted strictly in order 1,2,3; nothing is emitted before the slot-0 response.
REQ-037 Full: SIZE=4, 4 reads outstanding -> 5th read sees in_req_ready=0 and a concurrent write with out_req_ready=1 is accepted; after one pop, the 5th read is accepted the next cycle.
REQ-038 Back-pressure/wrap: out_rsp_ready held low for 10 cycles with a done head -> outputs stable; then stream 3*SIZE reads/responses -> tags are correct across the wrap.
REQ-039 Reset mid-operation: 3 reads outstanding, then reset_n=0 for 1 cycle -> count=0, out_rsp_valid=0, and a new read is allocated to slot 0.
REQ-040 Perf (with macro): hold a read blocked by full for 7 cycles -> perf_full_stalls=7.
